// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and the BRAM controller state type.
//   HTRANS_* : transfer type codes (IDLE, BUSY, NONSEQ, SEQ)
//   HSIZE_*  : transfer size codes (byte, halfword, word)
//   HRESP_*  : response codes (OKAY, ERROR)
//   ctrl_state_e : ahb_bram_ctrl FSM states
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_ERR1,
        ST_ERR2
    } ctrl_state_e;

    // NONSEQ/SEQ carry a real transfer; IDLE/BUSY do not.
    function automatic logic htrans_active(input logic [1:0] htrans);
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: htrans_active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  htrans_active = 1'b0;
            default:                   htrans_active = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_byte_lane.sv
// ahb_byte_lane: combinational AHB byte-lane decoder.
//   hsize_i   : HSIZE of the transfer
//   addr_lo_i : HADDR[1:0]
//   mask_o    : 4-bit byte enable (zero when illegal)
//   illegal_o : size > word, or misaligned halfword/word
module ahb_byte_lane
    import ahb_pkg::*;
(
    input  logic [2:0] hsize_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] mask_o,
    output logic       illegal_o
);

    always_comb begin
        mask_o    = '0;
        illegal_o = 1'b0;
        case (hsize_i)
            HSIZE_BYTE: mask_o = 4'b0001 << addr_lo_i;
            HSIZE_HALF: begin
                if (addr_lo_i[0]) illegal_o = 1'b1;
                else              mask_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
            end
            HSIZE_WORD: begin
                if (addr_lo_i != 2'b00) illegal_o = 1'b1;
                else                    mask_o    = '1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// ahb_bram_ctrl: AHB-Lite slave sequencing a simple dual-port BRAM
// (write port A, registered read port B) with a secondary loader on port A.
//   HCLK/HRESETn            : clock, async active-low reset
//   HSEL..HWDATA            : AHB-Lite slave inputs
//   HRDATA/HREADYOUT/HRESP  : AHB-Lite slave outputs
//   ld_req/ld_addr/ld_wdata : loader full-word write request
//   ld_gnt                  : loader write accepted this cycle
//   bram_addra/dina/wea     : BRAM write port
//   bram_addrb/doutb        : BRAM read port (doutb one cycle after addrb)
module ahb_bram_ctrl
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 14
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    input  logic [31:0]           HWDATA,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    input  logic                  ld_req,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [31:0]           ld_wdata,
    output logic                  ld_gnt,
    output logic [ADDR_WIDTH-1:0] bram_addra,
    output logic [31:0]           bram_dina,
    output logic [3:0]            bram_wea,
    output logic [ADDR_WIDTH-1:0] bram_addrb,
    input  logic [31:0]           bram_doutb
);

    ctrl_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            mask_q, mask_d;
    logic                  fwd_valid_q, fwd_valid_d;
    logic [31:0]           fwd_data_q, fwd_data_d;
    logic [3:0]            fwd_mask_q, fwd_mask_d;

    logic                  accept;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [3:0]            lane_mask;
    logic                  lane_illegal;
    logic                  unused_haddr;

    assign unused_haddr = ^HADDR[31:ADDR_WIDTH+2];

    ahb_byte_lane u_lane (
        .hsize_i   (HSIZE),
        .addr_lo_i (HADDR[1:0]),
        .mask_o    (lane_mask),
        .illegal_o (lane_illegal)
    );

    assign accept    = HSEL & htrans_active(HTRANS) & HREADY;
    assign word_addr = HADDR[ADDR_WIDTH+1:2];

    // Read address goes straight to the BRAM so doutb lands in the data phase.
    assign bram_addrb = word_addr;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            mask_q      <= '0;
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= '0;
            fwd_mask_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_data_q  <= fwd_data_d;
            fwd_mask_q  <= fwd_mask_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        mask_d      = mask_q;
        fwd_valid_d = 1'b0;
        fwd_data_d  = fwd_data_q;
        fwd_mask_d  = fwd_mask_q;

        if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (accept) begin
            addr_d = word_addr;
            mask_d = lane_mask;
            if (lane_illegal) state_d = ST_ERR1;
            else if (HWRITE)  state_d = ST_WR;
            else              state_d = ST_RD;
        end else begin
            state_d = ST_IDLE;
        end

        // A read of the word being written right now would see stale BRAM
        // data next cycle, so keep the in-flight write bytes for the merge.
        if (state_q == ST_WR && accept && !HWRITE && !lane_illegal &&
            word_addr == addr_q) begin
            fwd_valid_d = 1'b1;
            fwd_data_d  = HWDATA;
            fwd_mask_d  = mask_q;
        end
    end

    always_comb begin
        HREADYOUT = (state_q != ST_ERR1);
        HRESP     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;

        HRDATA = bram_doutb;
        for (int unsigned i = 0; i < 4; i++) begin
            if (fwd_valid_q && fwd_mask_q[i]) HRDATA[i*8 +: 8] = fwd_data_q[i*8 +: 8];
        end

        bram_addra = '0;
        bram_dina  = '0;
        bram_wea   = '0;
        ld_gnt     = 1'b0;
        if (state_q == ST_WR) begin
            bram_addra = addr_q;
            bram_wea   = mask_q;
            bram_dina  = HWDATA;
        end else if (ld_req && HRESETn) begin
            ld_gnt     = 1'b1;
            bram_addra = ld_addr;
            bram_wea   = '1;
            bram_dina  = ld_wdata;
        end
    end

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
module tb_ahb_bram_ctrl;

    localparam int unsigned AW = 8;

    logic          HCLK;
    logic          HRESETn;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic          HREADY;
    logic [31:0]   HWDATA;
    logic [31:0]   HRDATA;
    logic          HREADYOUT;
    logic          HRESP;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_wdata;
    logic          ld_gnt;
    logic [AW-1:0] bram_addra;
    logic [31:0]   bram_dina;
    logic [3:0]    bram_wea;
    logic [AW-1:0] bram_addrb;
    logic [31:0]   bram_doutb;

    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [31:0]   pre_data;
    logic [31:0]   mem [0:(1<<AW)-1];

    int            tests_run = 0;
    int            fails = 0;
    logic [31:0]   sb [$];
    logic [31:0]   exp_v;

    ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
        .bram_addra(bram_addra), .bram_dina(bram_dina), .bram_wea(bram_wea),
        .bram_addrb(bram_addrb), .bram_doutb(bram_doutb)
    );

    // Single slave on the bus: HREADY follows our own HREADYOUT.
    assign HREADY = HREADYOUT;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // BRAM model: byte-enabled write port, read-first registered read port.
    always @(posedge HCLK) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        for (int i = 0; i < 4; i++)
            if (bram_wea[i]) mem[bram_addra][i*8 +: 8] <= bram_dina[i*8 +: 8];
        bram_doutb <= mem[bram_addrb];
    end

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic addr(input logic w, input logic [31:0] a, input logic [2:0] s);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = w; HADDR = a; HSIZE = s;
    endtask

    task automatic idle;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge HCLK);
        tests_run++;
        if ({HREADYOUT, HRESP, ld_gnt, bram_wea} !== 7'b1_0_0_0000) begin
            fails++;
            $display("FAIL reset_values: got rdy/resp/gnt/wea=%b want 1000000",
                     {HREADYOUT, HRESP, ld_gnt, bram_wea});
        end
    endtask

    task automatic test_word_rw;
        addr(1'b1, 32'h10, 3'd2);
        tick();
        idle(); HWDATA = 32'hDEADBEEF;
        @(negedge HCLK);
        tests_run++;
        if ({bram_wea, bram_addra, bram_dina, HREADYOUT} !== {4'hF, 8'd4, 32'hDEADBEEF, 1'b1}) begin
            fails++;
            $display("FAIL word_write: got wea=%h addra=%h dina=%h rdy=%b want f 04 deadbeef 1",
                     bram_wea, bram_addra, bram_dina, HREADYOUT);
        end
        tick();
        @(negedge HCLK);
        tests_run++;
        if (bram_wea !== 4'h0) begin
            fails++;
            $display("FAIL word_write_once: got wea=%h want 0", bram_wea);
        end
        tick();
        addr(1'b0, 32'h10, 3'd2); sb.push_back(32'hDEADBEEF);
        tick();
        idle();
        @(negedge HCLK);
        tests_run++;
        exp_v = (sb.size() > 0) ? sb.pop_front() : 32'hX;
        if (HRDATA !== exp_v || HREADYOUT !== 1'b1) begin
            fails++;
            $display("FAIL word_read: got %h rdy=%b want %h rdy=1", HRDATA, HREADYOUT, exp_v);
        end
    endtask

    task automatic test_byte_write;
        preload(8'd4, 32'h11223344);
        addr(1'b1, 32'h13, 3'd0);
        tick();
        idle(); HWDATA = 32'hAA000000;
        @(negedge HCLK);
        tests_run++;
        if (bram_wea !== 4'b1000) begin
            fails++;
            $display("FAIL byte_mask: got wea=%b want 1000", bram_wea);
        end
        tick();
        addr(1'b0, 32'h10, 3'd2); sb.push_back(32'hAA223344);
        tick();
        idle();
        @(negedge HCLK);
        tests_run++;
        exp_v = (sb.size() > 0) ? sb.pop_front() : 32'hX;
        if (HRDATA !== exp_v) begin
            fails++;
            $display("FAIL byte_read: got %h want %h", HRDATA, exp_v);
        end
    endtask

    task automatic test_back_to_back;
        preload(8'd4, 32'h00000000);
        preload(8'd6, 32'h55555555);
        addr(1'b1, 32'h12, 3'd1);
        tick();
        addr(1'b0, 32'h10, 3'd2); HWDATA = 32'hBEEF0000; sb.push_back(32'hBEEF0000);
        @(negedge HCLK);
        tests_run++;
        if (bram_wea !== 4'b1100) begin
            fails++;
            $display("FAIL half_mask: got wea=%b want 1100", bram_wea);
        end
        tick();
        addr(1'b0, 32'h18, 3'd2); sb.push_back(32'h55555555);
        @(negedge HCLK);
        tests_run++;
        exp_v = (sb.size() > 0) ? sb.pop_front() : 32'hX;
        if (HRDATA !== exp_v || HREADYOUT !== 1'b1) begin
            fails++;
            $display("FAIL forward_read: got %h rdy=%b want %h rdy=1", HRDATA, HREADYOUT, exp_v);
        end
        tick();
        idle();
        @(negedge HCLK);
        tests_run++;
        exp_v = (sb.size() > 0) ? sb.pop_front() : 32'hX;
        if (HRDATA !== exp_v) begin
            fails++;
            $display("FAIL forward_cleared: got %h want %h", HRDATA, exp_v);
        end
    endtask

    task automatic test_error;
        preload(8'd0, 32'hCAFEF00D);
        addr(1'b1, 32'h02, 3'd2);
        tick();
        idle(); HWDATA = 32'hFFFFFFFF;
        @(negedge HCLK);
        tests_run++;
        if ({HREADYOUT, HRESP, bram_wea} !== 6'b0_1_0000) begin
            fails++;
            $display("FAIL err1: got rdy/resp/wea=%b want 010000", {HREADYOUT, HRESP, bram_wea});
        end
        tick();
        addr(1'b0, 32'h00, 3'd2); sb.push_back(32'hCAFEF00D);
        @(negedge HCLK);
        tests_run++;
        if ({HREADYOUT, HRESP} !== 2'b11) begin
            fails++;
            $display("FAIL err2: got rdy/resp=%b want 11", {HREADYOUT, HRESP});
        end
        tick();
        idle();
        @(negedge HCLK);
        tests_run++;
        exp_v = (sb.size() > 0) ? sb.pop_front() : 32'hX;
        if (HRDATA !== exp_v || HRESP !== 1'b0 || HREADYOUT !== 1'b1) begin
            fails++;
            $display("FAIL err_recover_read: got %h resp=%b rdy=%b want %h 0 1",
                     HRDATA, HRESP, HREADYOUT, exp_v);
        end
        tests_run++;
        if (mem[0] !== 32'hCAFEF00D) begin
            fails++;
            $display("FAIL err_no_write: got mem0=%h want cafef00d", mem[0]);
        end
    endtask

    task automatic test_idle_busy;
        HSEL = 1'b1; HTRANS = 2'b01; HWRITE = 1'b1; HADDR = 32'h10; HSIZE = 3'd2;
        tick();
        HSEL = 1'b0; HTRANS = 2'b10;
        @(negedge HCLK);
        tests_run++;
        if ({bram_wea, HREADYOUT, HRESP} !== 6'b0000_1_0) begin
            fails++;
            $display("FAIL busy_no_write: got wea/rdy/resp=%b want 000010", {bram_wea, HREADYOUT, HRESP});
        end
        tick();
        idle();
        @(negedge HCLK);
        tests_run++;
        if ({bram_wea, HREADYOUT, HRESP} !== 6'b0000_1_0) begin
            fails++;
            $display("FAIL unsel_no_write: got wea/rdy/resp=%b want 000010", {bram_wea, HREADYOUT, HRESP});
        end
    endtask

    task automatic test_loader;
        addr(1'b1, 32'h20, 3'd2);
        tick();
        idle(); HWDATA = 32'h0BADBEEF;
        ld_req = 1'b1; ld_addr = 8'd5; ld_wdata = 32'h12345678;
        @(negedge HCLK);
        tests_run++;
        if ({ld_gnt, bram_wea, bram_addra} !== {1'b0, 4'hF, 8'd8}) begin
            fails++;
            $display("FAIL ld_blocked: got gnt=%b wea=%h addra=%h want 0 f 08", ld_gnt, bram_wea, bram_addra);
        end
        tick();
        @(negedge HCLK);
        tests_run++;
        if ({ld_gnt, bram_wea, bram_addra, bram_dina} !== {1'b1, 4'hF, 8'd5, 32'h12345678}) begin
            fails++;
            $display("FAIL ld_grant: got gnt=%b wea=%h addra=%h dina=%h want 1 f 05 12345678",
                     ld_gnt, bram_wea, bram_addra, bram_dina);
        end
        tick();
        ld_req = 1'b0;
        addr(1'b0, 32'h14, 3'd2); sb.push_back(32'h12345678);
        tick();
        addr(1'b0, 32'h20, 3'd2); sb.push_back(32'h0BADBEEF);
        @(negedge HCLK);
        tests_run++;
        exp_v = (sb.size() > 0) ? sb.pop_front() : 32'hX;
        if (HRDATA !== exp_v) begin
            fails++;
            $display("FAIL ld_read: got %h want %h", HRDATA, exp_v);
        end
        tick();
        idle();
        @(negedge HCLK);
        tests_run++;
        exp_v = (sb.size() > 0) ? sb.pop_front() : 32'hX;
        if (HRDATA !== exp_v) begin
            fails++;
            $display("FAIL ld_ahb_read: got %h want %h", HRDATA, exp_v);
        end
    endtask

    task automatic test_reset_mid_write;
        preload(8'd6, 32'h600D600D);
        addr(1'b1, 32'h18, 3'd2);
        tick();
        idle(); HWDATA = 32'hFFFFFFFF;
        #2;
        tests_run++;
        if (bram_wea !== 4'hF) begin
            fails++;
            $display("FAIL rst_pre_wr: got wea=%h want f", bram_wea);
        end
        HRESETn = 1'b0; ld_req = 1'b1; ld_addr = 8'd6; ld_wdata = 32'hFFFFFFFF;
        #1;
        tests_run++;
        if ({bram_wea, HREADYOUT, HRESP, ld_gnt} !== 7'b0000_1_0_0) begin
            fails++;
            $display("FAIL rst_mid_wr: got wea/rdy/resp/gnt=%b want 0000100",
                     {bram_wea, HREADYOUT, HRESP, ld_gnt});
        end
        tick();
        tick();
        HRESETn = 1'b1; ld_req = 1'b0;
        tick();
        tests_run++;
        if (mem[6] !== 32'h600D600D) begin
            fails++;
            $display("FAIL rst_word_kept: got %h want 600d600d", mem[6]);
        end
        addr(1'b0, 32'h18, 3'd2); sb.push_back(32'h600D600D);
        tick();
        idle();
        @(negedge HCLK);
        tests_run++;
        exp_v = (sb.size() > 0) ? sb.pop_front() : 32'hX;
        if (HRDATA !== exp_v) begin
            fails++;
            $display("FAIL rst_read_back: got %h want %h", HRDATA, exp_v);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HSIZE = 3'd0; HWRITE = 1'b0;
        HWDATA = '0; ld_req = 1'b0; ld_addr = '0; ld_wdata = '0;
        test_reset();
        tick();
        HRESETn = 1'b1;
        tick();
        test_word_rw();
        tick();
        test_byte_write();
        test_back_to_back();
        tick();
        test_error();
        tick();
        test_idle_busy();
        tick();
        test_loader();
        tick();
        test_reset_mid_write();
        tick();
        tests_run++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
